// File: rtl/forwarding_hazard_unit.sv
// EX-stage operand forwarding selects and load-use stall detection for the MIPS pipeline.
// Define HAZARD_STATS_EN to add the stall_count / forward_count statistics ports.
module forwarding_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int STATS_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    output logic [1:0]            forward_a_sel,
    output logic [1:0]            forward_b_sel,
    output logic                  stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [STATS_W-1:0]    stall_count,
    output logic [STATS_W-1:0]    forward_count
`endif
);

    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_WB      = 2'b01;
    localparam logic [1:0] SEL_MEM     = 2'b10;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rs;
        logic                  uses_rt;
        logic [REG_ADDR_W-1:0] dest;
        logic                  regwrite;
        logic                  memread;
    } ex_stage_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  regwrite;
    } wr_stage_t;

    ex_stage_t ex_q;
    wr_stage_t mem_q;
    wr_stage_t wb_q;

    logic mem_valid_wr;
    logic wb_valid_wr;
    logic mem_hit_a;
    logic mem_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;
    logic load_use;

    // A producer writing $0 never forwards: $0 is hard-wired zero.
    always_comb begin
        mem_valid_wr = mem_q.regwrite && (mem_q.dest != '0);
        wb_valid_wr  = wb_q.regwrite && (wb_q.dest != '0);
        mem_hit_a    = ex_q.uses_rs && mem_valid_wr && (mem_q.dest == ex_q.rs);
        mem_hit_b    = ex_q.uses_rt && mem_valid_wr && (mem_q.dest == ex_q.rt);
        wb_hit_a     = ex_q.uses_rs && wb_valid_wr && (wb_q.dest == ex_q.rs);
        wb_hit_b     = ex_q.uses_rt && wb_valid_wr && (wb_q.dest == ex_q.rt);
        load_use     = !flush && ex_q.memread && ex_q.regwrite && (ex_q.dest != '0) &&
                       ((id_uses_rs && (ex_q.dest == id_rs)) ||
                        (id_uses_rt && (ex_q.dest == id_rt)));
    end

    always_comb begin
        forward_a_sel = SEL_REGFILE;
        forward_b_sel = SEL_REGFILE;
        stall         = 1'b0;
        if (!reset) begin
            if (mem_hit_a)      forward_a_sel = SEL_MEM;
            else if (wb_hit_a)  forward_a_sel = SEL_WB;
            if (mem_hit_b)      forward_b_sel = SEL_MEM;
            else if (wb_hit_b)  forward_b_sel = SEL_WB;
            stall = load_use;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q.dest     <= ex_q.dest;
            mem_q.regwrite <= ex_q.regwrite;
            wb_q           <= mem_q;
            // A stalled or squashed instruction leaves a bubble in EX.
            if (stall || flush) begin
                ex_q <= '0;
            end else begin
                ex_q.rs       <= id_rs;
                ex_q.rt       <= id_rt;
                ex_q.uses_rs  <= id_uses_rs;
                ex_q.uses_rt  <= id_uses_rt;
                ex_q.dest     <= id_dest;
                ex_q.regwrite <= id_regwrite;
                ex_q.memread  <= id_memread;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count   <= '0;
            forward_count <= '0;
        end else begin
            if (stall) stall_count <= stall_count + 1'b1;
            if ((forward_a_sel != SEL_REGFILE) || (forward_b_sel != SEL_REGFILE))
                forward_count <= forward_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed, table-driven bench for forwarding_hazard_unit, with hand sequences
// for flush, back-to-back loads and reset asserted during a stall.
module tb_forwarding_hazard_unit;

  localparam int RW = 5;
  localparam int SW = 32;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic [RW-1:0] id_dest;
  logic          id_regwrite;
  logic          id_memread;
  logic [1:0]    forward_a_sel;
  logic [1:0]    forward_b_sel;
  logic          stall;
`ifdef HAZARD_STATS_EN
  logic [SW-1:0] stall_count;
  logic [SW-1:0] forward_count;
`endif

  int checks;
  int failures;
  logic [SW-1:0] exp_stall_cnt;
  logic [SW-1:0] exp_fwd_cnt;

  typedef struct {
    logic          flush;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          urs;
    logic          urt;
    logic [RW-1:0] dest;
    logic          rw;
    logic          mr;
    logic [1:0]    exp_a;
    logic [1:0]    exp_b;
    logic          exp_stall;
  } vec_t;

  vec_t vecs[$];
  vec_t hand[$];

  forwarding_hazard_unit #(.REG_ADDR_W(RW), .STATS_W(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_dest      (id_dest),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .forward_a_sel(forward_a_sel),
    .forward_b_sel(forward_b_sel),
    .stall        (stall)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count  (stall_count),
    .forward_count(forward_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic fl, input int rs, input int rt, input logic urs,
                             input logic urt, input int dest, input logic rw, input logic mr,
                             input logic [1:0] ea, input logic [1:0] eb, input logic es);
    vec_t r;
    r.flush = fl;
    r.rs = RW'(rs);
    r.rt = RW'(rt);
    r.urs = urs;
    r.urt = urt;
    r.dest = RW'(dest);
    r.rw = rw;
    r.mr = mr;
    r.exp_a = ea;
    r.exp_b = eb;
    r.exp_stall = es;
    return r;
  endfunction

  function automatic vec_t nop(input logic [1:0] ea, input logic [1:0] eb);
    return v(0, 0, 0, 0, 0, 0, 0, 0, ea, eb, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // driver: present ID inputs, check at negedge, optionally take the edge
  task automatic run_vec(input string tag, input vec_t t, input bit advance);
    flush       = t.flush;
    id_rs       = t.rs;
    id_rt       = t.rt;
    id_uses_rs  = t.urs;
    id_uses_rt  = t.urt;
    id_dest     = t.dest;
    id_regwrite = t.rw;
    id_memread  = t.mr;
    @(negedge clk);
    chk({tag, "_a"}, 32'(forward_a_sel), 32'(t.exp_a));
    chk({tag, "_b"}, 32'(forward_b_sel), 32'(t.exp_b));
    chk({tag, "_stall"}, 32'(stall), 32'(t.exp_stall));
`ifdef HAZARD_STATS_EN
    chk({tag, "_stall_cnt"}, stall_count, exp_stall_cnt);
    chk({tag, "_fwd_cnt"}, forward_count, exp_fwd_cnt);
`endif
    if (advance) begin
      @(posedge clk);
      #1;
      if (t.exp_stall) exp_stall_cnt = exp_stall_cnt + 1'b1;
      if ((t.exp_a != 2'b00) || (t.exp_b != 2'b00)) exp_fwd_cnt = exp_fwd_cnt + 1'b1;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_stall_cnt = '0;
    exp_fwd_cnt = '0;

    // ALU chain: add $8; sub uses $8 -> MEM forward on rs for one cycle
    vecs.push_back(v(0, 1, 2, 1, 1, 8, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(v(0, 8, 3, 1, 1, 11, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(nop(2'b10, 2'b00));
    vecs.push_back(nop(2'b00, 2'b00));
    // distance-2 on rt -> WB forward
    vecs.push_back(v(0, 1, 2, 1, 1, 9, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(v(0, 5, 6, 1, 1, 12, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(v(0, 7, 9, 1, 1, 13, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(nop(2'b00, 2'b01));
    // double producer of $10 -> MEM wins
    vecs.push_back(v(0, 1, 2, 1, 1, 10, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(v(0, 3, 4, 1, 1, 10, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(v(0, 10, 5, 1, 1, 14, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(nop(2'b10, 2'b00));
    vecs.push_back(nop(2'b00, 2'b00));
    // load-use on rs: one stall, bubble, then WB forward
    vecs.push_back(v(0, 1, 0, 1, 0, 4, 1, 1, 2'b00, 2'b00, 0));
    vecs.push_back(v(0, 4, 2, 1, 1, 15, 1, 0, 2'b00, 2'b00, 1));
    vecs.push_back(v(0, 4, 2, 1, 1, 15, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(nop(2'b01, 2'b00));
    vecs.push_back(nop(2'b00, 2'b00));
    // $0 producer never forwards
    vecs.push_back(v(0, 1, 2, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 16, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(nop(2'b00, 2'b00));
    vecs.push_back(nop(2'b00, 2'b00));
    // load of $0 never stalls
    vecs.push_back(v(0, 1, 0, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 17, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(nop(2'b00, 2'b00));
    // flush with a load-use pending: no stall, consumer squashed
    vecs.push_back(v(0, 1, 0, 1, 0, 4, 1, 1, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, 4, 2, 1, 1, 15, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(nop(2'b00, 2'b00));
    vecs.push_back(nop(2'b00, 2'b00));
    // back-to-back loads, each with its own single stall
    vecs.push_back(v(0, 1, 0, 1, 0, 5, 1, 1, 2'b00, 2'b00, 0));
    vecs.push_back(v(0, 5, 0, 1, 0, 6, 1, 1, 2'b00, 2'b00, 1));
    vecs.push_back(v(0, 5, 0, 1, 0, 6, 1, 1, 2'b00, 2'b00, 0));
    vecs.push_back(v(0, 6, 3, 1, 1, 7, 1, 0, 2'b01, 2'b00, 1));
    vecs.push_back(v(0, 6, 3, 1, 1, 7, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(nop(2'b01, 2'b00));
    vecs.push_back(nop(2'b00, 2'b00));
    // load-use through rt only
    vecs.push_back(v(0, 1, 0, 1, 0, 4, 1, 1, 2'b00, 2'b00, 0));
    vecs.push_back(v(0, 1, 4, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1));
    vecs.push_back(v(0, 1, 4, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(nop(2'b00, 2'b01));
    // rt field matches the load but is not read -> no stall
    vecs.push_back(v(0, 1, 0, 1, 0, 4, 1, 1, 2'b00, 2'b00, 0));
    vecs.push_back(v(0, 1, 4, 1, 0, 18, 1, 0, 2'b00, 2'b00, 0));
    vecs.push_back(nop(2'b00, 2'b00));
    vecs.push_back(nop(2'b00, 2'b00));

    // reset state, with ID inputs that would otherwise look like a consumer
    reset = 1'b1;
    flush = 1'b0;
    id_rs = 5'd4; id_rt = 5'd4; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    id_dest = 5'd4; id_regwrite = 1'b1; id_memread = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a", 32'(forward_a_sel), 32'd0);
    chk("rst_b", 32'(forward_b_sel), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      run_vec($sformatf("v%0d", i), vecs[i], 1'b1);

    // reset asserted during a cycle that both stalls and forwards
    hand.push_back(v(0, 1, 0, 1, 0, 5, 1, 1, 2'b00, 2'b00, 0));
    hand.push_back(v(0, 5, 0, 1, 0, 6, 1, 1, 2'b00, 2'b00, 1));
    hand.push_back(v(0, 5, 0, 1, 0, 6, 1, 1, 2'b00, 2'b00, 0));
    for (int i = 0; i < hand.size(); i++)
      run_vec($sformatf("h%0d", i), hand[i], 1'b1);
    run_vec("h3", v(0, 6, 3, 1, 1, 7, 1, 0, 2'b01, 2'b00, 1), 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_a", 32'(forward_a_sel), 32'd0);
    chk("midrst_b", 32'(forward_b_sel), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    exp_stall_cnt = '0;
    exp_fwd_cnt = '0;
    @(negedge clk);
`ifdef HAZARD_STATS_EN
    chk("midrst_stall_cnt", stall_count, exp_stall_cnt);
    chk("midrst_fwd_cnt", forward_count, exp_fwd_cnt);
`endif
    chk("midrst_hold_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      run_vec($sformatf("post%0d", i), nop(2'b00, 2'b00), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
